// File: rtl/psum_accum_array.sv
// rtl/psum_accum_array.sv - multi-lane partial-sum accumulator with relu, saturate/wrap narrowing and sticky overflow

module psum_accum_array #(
    parameter int NUM_KERNEL = 4,
    parameter int BIT_WIDTH  = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int OUT_WIDTH  = 8,
    parameter int REG_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [BIT_WIDTH*NUM_KERNEL-1:0] i_psum,
    input  logic [NUM_KERNEL-1:0]           i_psum_val,
    output logic [OUT_WIDTH*NUM_KERNEL-1:0] o_psum,
    output logic [NUM_KERNEL-1:0]           o_psum_val,
    output logic [NUM_KERNEL-1:0]           o_ovf,
    output logic                            o_busy,
    input  logic [REG_WIDTH-1:0]            i_conf_ctrl,
    input  logic [REG_WIDTH-1:0]            i_conf_cnt,
    input  logic [REG_WIDTH-1:0]            i_conf_knx
);

    // Narrowing bounds expressed in accumulator width so comparisons stay signed and same-sized.
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

    // Decoded configuration shared by all lanes.
    logic                 cfg_en;
    logic                 cfg_relu;
    logic                 cfg_sat;
    logic                 cfg_clear;
    logic [REG_WIDTH-1:0] cfg_cnt;

    assign cfg_en    = i_conf_ctrl[0];
    assign cfg_relu  = i_conf_ctrl[1];
    assign cfg_sat   = i_conf_ctrl[2];
    assign cfg_clear = i_conf_ctrl[3];
    // A group size of zero behaves as one psum per group.
    assign cfg_cnt   = (i_conf_cnt == '0) ? REG_WIDTH'(1) : i_conf_cnt;

    // Reserved configuration bits are intentionally ignored.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{i_conf_ctrl[REG_WIDTH-1:4], i_conf_knx[REG_WIDTH-1:NUM_KERNEL]};

    // Per-lane next-state busy indication, combined into the registered o_busy.
    logic [NUM_KERNEL-1:0] lane_busy_d;

    genvar k;
    generate
        for (k = 0; k < NUM_KERNEL; k++) begin : g_lane
            logic [REG_WIDTH-1:0]        cnt_q;
            logic [REG_WIDTH-1:0]        cnt_d;
            logic [REG_WIDTH-1:0]        cnt_lat_q;
            logic                        relu_lat_q;
            logic                        sat_lat_q;
            logic signed [ACC_WIDTH-1:0] acc_q;
            logic [OUT_WIDTH-1:0]        psum_q;
            logic                        val_q;
            logic                        ovf_q;

            logic                        accept;
            logic                        idle;
            logic                        done;
            logic [REG_WIDTH-1:0]        cnt_inc;
            logic [REG_WIDTH-1:0]        grp_cnt;
            logic                        grp_relu;
            logic                        grp_sat;
            logic signed [ACC_WIDTH-1:0] in_ext;
            logic signed [ACC_WIDTH-1:0] sum_add;
            logic signed [ACC_WIDTH-1:0] acc_next;
            logic signed [ACC_WIDTH-1:0] relu_val;
            logic signed [ACC_WIDTH-1:0] wrap_ext;
            logic                        add_ovf;
            logic [OUT_WIDTH-1:0]        narrow_val;
            logic                        narrow_ovf;

            // Accept, accumulate and narrow for this lane; config is taken live only on the group's first psum.
            always_comb begin
                accept     = i_psum_val[k] & cfg_en & i_conf_knx[k] & ~cfg_clear;
                idle       = (cnt_q == '0);
                cnt_inc    = cnt_q + REG_WIDTH'(1);
                grp_cnt    = idle ? cfg_cnt  : cnt_lat_q;
                grp_relu   = idle ? cfg_relu : relu_lat_q;
                grp_sat    = idle ? cfg_sat  : sat_lat_q;
                in_ext     = ACC_WIDTH'($signed(i_psum[k*BIT_WIDTH +: BIT_WIDTH]));
                sum_add    = acc_q + in_ext;
                // Signed overflow: operands agree in sign but the sum does not.
                add_ovf    = ~idle & (acc_q[ACC_WIDTH-1] == in_ext[ACC_WIDTH-1])
                                   & (sum_add[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
                acc_next   = idle ? in_ext : sum_add;
                done       = accept & (cnt_inc == grp_cnt);

                relu_val   = (grp_relu && acc_next[ACC_WIDTH-1]) ? '0 : acc_next;
                wrap_ext   = ACC_WIDTH'($signed(relu_val[OUT_WIDTH-1:0]));
                narrow_val = relu_val[OUT_WIDTH-1:0];
                narrow_ovf = 1'b0;
                if (grp_sat) begin
                    if (relu_val > OUT_MAX) begin
                        narrow_val = OUT_MAX[OUT_WIDTH-1:0];
                        narrow_ovf = 1'b1;
                    end else if (relu_val < OUT_MIN) begin
                        narrow_val = OUT_MIN[OUT_WIDTH-1:0];
                        narrow_ovf = 1'b1;
                    end
                end else begin
                    narrow_ovf = (wrap_ext != relu_val);
                end

                cnt_d = cnt_q;
                if (cfg_clear || done) begin
                    cnt_d = '0;
                end else if (accept) begin
                    cnt_d = cnt_inc;
                end
            end

            // Lane state: counter, accumulator, latched group config, result register and sticky flag.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q      <= '0;
                    cnt_lat_q  <= '0;
                    relu_lat_q <= 1'b0;
                    sat_lat_q  <= 1'b0;
                    acc_q      <= '0;
                    psum_q     <= '0;
                    val_q      <= 1'b0;
                    ovf_q      <= 1'b0;
                end else if (cfg_clear) begin
                    cnt_q      <= '0;
                    acc_q      <= '0;
                    val_q      <= 1'b0;
                    ovf_q      <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    val_q <= done;
                    ovf_q <= ovf_q | (accept & add_ovf) | (done & narrow_ovf);
                    if (done) begin
                        acc_q  <= '0;
                        psum_q <= narrow_val;
                    end else if (accept) begin
                        acc_q <= acc_next;
                        if (idle) begin
                            cnt_lat_q  <= cfg_cnt;
                            relu_lat_q <= cfg_relu;
                            sat_lat_q  <= cfg_sat;
                        end
                    end
                end
            end

            assign lane_busy_d[k]                   = (cnt_d != '0);
            assign o_psum[k*OUT_WIDTH +: OUT_WIDTH] = psum_q;
            assign o_psum_val[k]                    = val_q;
            assign o_ovf[k]                         = ovf_q;
        end
    endgenerate

    // Registered busy: high while any lane is mid-group.
    logic busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |lane_busy_d;
        end
    end

    assign o_busy = busy_q;

endmodule

// File: tb/tb_psum_accum_array.sv
// tb/tb_psum_accum_array.sv - directed self-checking bench for psum_accum_array

module tb_psum_accum_array;

    logic        clk;
    logic        rst;
    logic [31:0] i_psum;
    logic [3:0]  i_psum_val;
    logic [31:0] o_psum;
    logic [3:0]  o_psum_val;
    logic [3:0]  o_ovf;
    logic        o_busy;
    logic [31:0] i_conf_ctrl;
    logic [31:0] i_conf_cnt;
    logic [31:0] i_conf_knx;

    int total;
    int bad;

    psum_accum_array dut (
        .clk         (clk),
        .rst         (rst),
        .i_psum      (i_psum),
        .i_psum_val  (i_psum_val),
        .o_psum      (o_psum),
        .o_psum_val  (o_psum_val),
        .o_ovf       (o_ovf),
        .o_busy      (o_busy),
        .i_conf_ctrl (i_conf_ctrl),
        .i_conf_cnt  (i_conf_cnt),
        .i_conf_knx  (i_conf_knx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] v, input logic [3:0] val);
        i_psum     = {4{v}};
        i_psum_val = val;
    endtask

    task automatic do_clear;
        i_psum_val  = 4'h0;
        i_conf_ctrl = i_conf_ctrl | 32'h8;
        step();
        i_conf_ctrl = i_conf_ctrl & ~32'h8;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(8'd9, 4'hF);
        i_conf_ctrl = 32'h1;
        step();
        step();
        total++; if (o_psum !== 32'h0) begin bad++; $display("FAIL reset_psum got=%h want=%h", o_psum, 32'h0); end
        total++; if (o_psum_val !== 4'h0) begin bad++; $display("FAIL reset_val got=%h want=%h", o_psum_val, 4'h0); end
        total++; if (o_ovf !== 4'h0) begin bad++; $display("FAIL reset_ovf got=%h want=%h", o_ovf, 4'h0); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        drive(8'd0, 4'h0);
        rst = 1'b0;
        step();
    endtask

    task automatic test_disabled;
        i_conf_ctrl = 32'h0;
        i_conf_cnt  = 32'd1;
        drive(8'd7, 4'hF);
        step();
        total++; if (o_psum_val !== 4'h0) begin bad++; $display("FAIL disabled_val got=%h want=%h", o_psum_val, 4'h0); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL disabled_busy got=%b want=0", o_busy); end
        drive(8'd0, 4'h0);
    endtask

    task automatic test_basic;
        i_conf_ctrl = 32'h5;
        i_conf_cnt  = 32'd3;
        drive(8'd10, 4'hF); step();
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", o_busy); end
        drive(8'd20, 4'hF); step();
        total++; if (o_psum_val !== 4'h0) begin bad++; $display("FAIL basic_early_val got=%h want=%h", o_psum_val, 4'h0); end
        drive(8'd30, 4'hF); step();
        total++; if (o_psum_val !== 4'hF) begin bad++; $display("FAIL basic_val got=%h want=%h", o_psum_val, 4'hF); end
        total++; if (o_psum !== {4{8'd60}}) begin bad++; $display("FAIL basic_psum got=%h want=%h", o_psum, {4{8'd60}}); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", o_busy); end
        drive(8'd0, 4'h0); step();
        total++; if (o_psum_val !== 4'h0) begin bad++; $display("FAIL basic_strobe got=%h want=%h", o_psum_val, 4'h0); end
        total++; if (o_psum !== {4{8'd60}}) begin bad++; $display("FAIL basic_hold got=%h want=%h", o_psum, {4{8'd60}}); end
        total++; if (o_ovf !== 4'h0) begin bad++; $display("FAIL basic_ovf got=%h want=%h", o_ovf, 4'h0); end
    endtask

    task automatic test_sat_wrap;
        do_clear();
        i_conf_ctrl = 32'h5;
        i_conf_cnt  = 32'd2;
        drive(8'd100, 4'hF); step();
        drive(8'd100, 4'hF); step();
        total++; if (o_psum !== {4{8'h7F}}) begin bad++; $display("FAIL sat_pos_psum got=%h want=%h", o_psum, {4{8'h7F}}); end
        total++; if (o_ovf !== 4'hF) begin bad++; $display("FAIL sat_pos_ovf got=%h want=%h", o_ovf, 4'hF); end
        drive(8'd0, 4'h0); step();
        total++; if (o_ovf !== 4'hF) begin bad++; $display("FAIL sat_sticky got=%h want=%h", o_ovf, 4'hF); end
        do_clear();
        total++; if (o_ovf !== 4'h0) begin bad++; $display("FAIL clear_ovf got=%h want=%h", o_ovf, 4'h0); end
        drive(8'h9C, 4'hF); step();
        drive(8'h9C, 4'hF); step();
        total++; if (o_psum !== {4{8'h80}}) begin bad++; $display("FAIL sat_neg_psum got=%h want=%h", o_psum, {4{8'h80}}); end
        do_clear();
        i_conf_ctrl = 32'h1;
        drive(8'd100, 4'hF); step();
        drive(8'd100, 4'hF); step();
        total++; if (o_psum !== {4{8'hC8}}) begin bad++; $display("FAIL wrap_psum got=%h want=%h", o_psum, {4{8'hC8}}); end
        total++; if (o_ovf !== 4'hF) begin bad++; $display("FAIL wrap_ovf got=%h want=%h", o_ovf, 4'hF); end
        drive(8'd0, 4'h0);
    endtask

    task automatic test_relu;
        do_clear();
        i_conf_ctrl = 32'h7;
        i_conf_cnt  = 32'd2;
        drive(8'hFB, 4'hF); step();
        drive(8'hF9, 4'hF); step();
        total++; if (o_psum !== 32'h0) begin bad++; $display("FAIL relu_psum got=%h want=%h", o_psum, 32'h0); end
        total++; if (o_psum_val !== 4'hF) begin bad++; $display("FAIL relu_val got=%h want=%h", o_psum_val, 4'hF); end
        total++; if (o_ovf !== 4'h0) begin bad++; $display("FAIL relu_ovf got=%h want=%h", o_ovf, 4'h0); end
        i_conf_ctrl = 32'h5;
        drive(8'hFB, 4'hF); step();
        drive(8'hF9, 4'hF); step();
        total++; if (o_psum !== {4{8'hF4}}) begin bad++; $display("FAIL norelu_psum got=%h want=%h", o_psum, {4{8'hF4}}); end
        total++; if (o_ovf !== 4'h0) begin bad++; $display("FAIL norelu_ovf got=%h want=%h", o_ovf, 4'h0); end
        drive(8'd0, 4'h0);
    endtask

    task automatic test_back_to_back;
        i_conf_ctrl = 32'h5;
        i_conf_cnt  = 32'd0;
        for (int v = 1; v <= 3; v++) begin
            drive(8'(v), 4'hF); step();
            total++; if (o_psum_val !== 4'hF) begin bad++; $display("FAIL b2b_val[%0d] got=%h want=%h", v, o_psum_val, 4'hF); end
            total++; if (o_psum !== {4{8'(v)}}) begin bad++; $display("FAIL b2b_psum[%0d] got=%h want=%h", v, o_psum, {4{8'(v)}}); end
            total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy[%0d] got=%b want=0", v, o_busy); end
        end
        drive(8'd0, 4'h0); step();
    endtask

    task automatic test_cnt_change;
        i_conf_ctrl = 32'h5;
        i_conf_cnt  = 32'd4;
        drive(8'd1, 4'hF); step();
        drive(8'd2, 4'hF); step();
        i_conf_cnt  = 32'd2;
        drive(8'd3, 4'hF); step();
        total++; if (o_psum_val !== 4'h0) begin bad++; $display("FAIL cntchg_early got=%h want=%h", o_psum_val, 4'h0); end
        drive(8'd4, 4'hF); step();
        total++; if (o_psum !== {4{8'd10}} || o_psum_val !== 4'hF) begin bad++; $display("FAIL cntchg_grp1 got=%h/%h want=%h/f", o_psum, o_psum_val, {4{8'd10}}); end
        drive(8'd5, 4'hF); step();
        drive(8'd6, 4'hF); step();
        total++; if (o_psum !== {4{8'd11}} || o_psum_val !== 4'hF) begin bad++; $display("FAIL cntchg_grp2 got=%h/%h want=%h/f", o_psum, o_psum_val, {4{8'd11}}); end
        drive(8'd0, 4'h0); step();
    endtask

    task automatic test_clear;
        i_conf_ctrl = 32'h5;
        i_conf_cnt  = 32'd3;
        drive(8'd40, 4'hF); step();
        drive(8'd40, 4'hF); step();
        i_conf_ctrl = 32'hD;
        drive(8'd50, 4'hF); step();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL clear_busy got=%b want=0", o_busy); end
        total++; if (o_psum_val !== 4'h0) begin bad++; $display("FAIL clear_val got=%h want=%h", o_psum_val, 4'h0); end
        i_conf_ctrl = 32'h5;
        drive(8'd0, 4'h0); step();
        total++; if (o_psum_val !== 4'h0) begin bad++; $display("FAIL clear_noout got=%h want=%h", o_psum_val, 4'h0); end
        drive(8'd1, 4'hF); step();
        drive(8'd2, 4'hF); step();
        drive(8'd3, 4'hF); step();
        total++; if (o_psum !== {4{8'd6}} || o_psum_val !== 4'hF) begin bad++; $display("FAIL clear_fresh got=%h/%h want=%h/f", o_psum, o_psum_val, {4{8'd6}}); end
        drive(8'd0, 4'h0); step();
    endtask

    task automatic test_mask;
        i_conf_ctrl = 32'h5;
        i_conf_cnt  = 32'd2;
        i_conf_knx  = 32'hF;
        i_psum = {8'd4, 8'd3, 8'd2, 8'd1}; i_psum_val = 4'hF; step();
        i_conf_knx = 32'h5;
        i_psum = {4{8'd10}}; i_psum_val = 4'hF; step();
        total++; if (o_psum_val !== 4'h5) begin bad++; $display("FAIL mask_val got=%h want=%h", o_psum_val, 4'h5); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL mask_busy got=%b want=1", o_busy); end
        i_conf_knx = 32'hF;
        i_psum = {8'd40, 8'd0, 8'd20, 8'd0}; i_psum_val = 4'hA; step();
        total++; if (o_psum_val !== 4'hA) begin bad++; $display("FAIL mask_resume_val got=%h want=%h", o_psum_val, 4'hA); end
        total++; if (o_psum !== 32'h2C0D160B) begin bad++; $display("FAIL mask_psum got=%h want=%h", o_psum, 32'h2C0D160B); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL mask_busy_end got=%b want=0", o_busy); end
        drive(8'd0, 4'h0); step();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        i_psum      = '0;
        i_psum_val  = '0;
        i_conf_ctrl = '0;
        i_conf_cnt  = '0;
        i_conf_knx  = 32'hF;
        test_reset();
        test_disabled();
        test_basic();
        test_sat_wrap();
        test_relu();
        test_back_to_back();
        test_cnt_change();
        test_clear();
        test_mask();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
